// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder that sits between the CPU control unit and a
// single-port synchronous RAM. It takes one fetch/load/store at a time,
// drives the RAM, waits out the RAM latency and returns one response pulse.
// Priority when several requests are raised together: store > load > fetch.
//
// Optional feature macro: MEM_RESP_MISALIGN_EN
//   defined   : an access with req_addr[0]=1 skips the RAM entirely and
//               completes one cycle later with misalign_err pulsed
//   undefined : req_addr[0] is ignored, so an odd address reads the even word
module cpu_mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,   // legal 1..4
    parameter int WR_LAT = 1    // legal 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_fetch,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic              resp_is_instr,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LAT);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_count;
    logic              r_is_fetch;
    logic              r_misalign;
    logic              r_mem_wren;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_resp_data;

    logic              w_any_req;
    logic              w_accept;
    logic              w_misalign;
    logic              w_unused_addr;

    assign w_any_req = req_store | req_load | req_fetch;
    assign w_accept  = (r_state == S_IDLE) && w_any_req;

`ifdef MEM_RESP_MISALIGN_EN
    // An odd byte address is a misaligned word access.
    assign w_misalign = req_addr[0];
`else
    // Odd addresses simply alias onto the even word.
    assign w_misalign = 1'b0;
`endif

    // Address bits outside [ADDR_W:1] are deliberately dropped (aliasing).
    assign w_unused_addr = ^req_addr;

    // State register; an asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; each wait state exits when its counter has run out.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_state_next = S_DONE;
                    end else if (req_store) begin
                        w_state_next = S_WR_WAIT;
                    end else begin
                        w_state_next = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_count == 3'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_WR_WAIT: begin
                if (r_count == 3'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture at accept, RAM drive, latency counter and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= 3'd0;
            r_is_fetch  <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_is_fetch <= !req_store && !req_load;
            r_misalign <= w_misalign;
            if (!w_misalign) begin
                r_mem_addr  <= req_addr[ADDR_W:1];
                r_mem_wdata <= req_wdata;
                r_mem_wren  <= req_store;
                r_count     <= req_store ? WR_CNT : RD_CNT;
            end
        end else begin
            // The write strobe only ever lasts the first cycle after accept.
            r_mem_wren <= 1'b0;
            if ((r_state == S_RD_WAIT || r_state == S_WR_WAIT) && r_count != 3'd0) begin
                r_count <= r_count - 3'd1;
            end
            if (r_state == S_RD_WAIT && r_count == 3'd0) begin
                r_resp_data <= mem_rdata;
            end
        end
    end

    assign stall         = (r_state != S_IDLE);
    assign resp_valid    = (r_state == S_DONE);
    assign resp_is_instr = (r_state == S_DONE) && r_is_fetch;
    assign misalign_err  = (r_state == S_DONE) && r_misalign;
    assign resp_data     = r_resp_data;
    assign mem_addr      = r_mem_addr;
    assign mem_wren      = r_mem_wren;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed testbench for cpu_mem_responder. Instance u_dut uses RD_LAT=1 with a
// one-cycle RAM model; instance u_dut_b uses RD_LAT=4 with a four-stage RAM
// model whose read data is a fixed pattern of the word address.
module tb_cpu_mem_responder;

    logic        clk;
    logic        reset;

    logic        req_fetch, req_load, req_store;
    logic [15:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_is_instr, misalign_err;
    logic [15:0] resp_data, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_wren;

    logic        req_fetch_b, req_load_b, req_store_b;
    logic [15:0] req_addr_b, req_wdata_b;
    logic        stall_b, resp_valid_b, resp_is_instr_b, misalign_err_b;
    logic [15:0] resp_data_b, mem_wdata_b, mem_rdata_b;
    logic [7:0]  mem_addr_b;
    logic        mem_wren_b;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .WR_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_fetch(req_fetch), .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_is_instr(resp_is_instr),
        .resp_data(resp_data), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .misalign_err(misalign_err)
    );

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .RD_LAT(4), .WR_LAT(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_fetch(req_fetch_b), .req_load(req_load_b), .req_store(req_store_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .stall(stall_b), .resp_valid(resp_valid_b), .resp_is_instr(resp_is_instr_b),
        .resp_data(resp_data_b), .mem_addr(mem_addr_b), .mem_wren(mem_wren_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .misalign_err(misalign_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model A: preset contents for a few words, one-cycle registered read.
    function automatic logic [15:0] ram_init(input logic [7:0] a);
        case (a)
            8'h01:   ram_init = 16'hA0A1;
            8'h05:   ram_init = 16'h1234;
            8'h09:   ram_init = 16'h5555;
            default: ram_init = {8'h5A, a};
        endcase
    endfunction

    logic [15:0]  ram_data [0:255];
    logic [255:0] ram_wr = '0;

    always @(posedge clk) begin
        if (mem_wren) begin
            ram_data[mem_addr] <= mem_wdata;
            ram_wr[mem_addr]   <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram_data[mem_addr] : ram_init(mem_addr);
    end

    // RAM model B: four-cycle read pipeline returning {0xC3, word address}.
    logic [15:0] rb_s1, rb_s2, rb_s3;
    always @(posedge clk) begin
        rb_s1       <= {8'hC3, mem_addr_b};
        rb_s2       <= rb_s1;
        rb_s3       <= rb_s2;
        mem_rdata_b <= rb_s3;
    end

    // Raise a request during an IDLE cycle (T); returns in cycle T+1.
    task automatic issue(input logic st, input logic ld, input logic fe,
                         input logic [15:0] addr, input logic [15:0] wd);
        @(negedge clk);
        req_store = st;
        req_load  = ld;
        req_fetch = fe;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
        n_checks++; if (resp_data !== 16'h0000) $display("FAIL reset_resp_data got=%h exp=0000", resp_data); else n_pass++;
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); else n_pass++;
        n_checks++; if (mem_wren !== 1'b0) $display("FAIL reset_mem_wren got=%b exp=0", mem_wren); else n_pass++;
        n_checks++; if (mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign_err); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_fetch;
        issue(1'b0, 1'b0, 1'b1, 16'h000A, 16'h0000);
        n_checks++; if (mem_addr !== 8'h05) $display("FAIL fetch_mem_addr got=%h exp=05", mem_addr); else n_pass++;
        n_checks++; if (stall !== 1'b1) $display("FAIL fetch_stall_t1 got=%b exp=1", stall); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL fetch_early_t1 got=%b exp=0", resp_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL fetch_early_t2 got=%b exp=0", resp_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL fetch_resp_valid got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (resp_is_instr !== 1'b1) $display("FAIL fetch_is_instr got=%b exp=1", resp_is_instr); else n_pass++;
        n_checks++; if (resp_data !== 16'h1234) $display("FAIL fetch_data got=%h exp=1234", resp_data); else n_pass++;
        $display("txn fetch addr=000A data=%h", resp_data);
        req_fetch = 1'b0;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL fetch_idle_stall got=%b exp=0", stall); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL fetch_single_pulse got=%b exp=0", resp_valid); else n_pass++;
    endtask

    task automatic test_priority;
        issue(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        n_checks++; if (mem_wren !== 1'b1) $display("FAIL prio_wren_t1 got=%b exp=1", mem_wren); else n_pass++;
        n_checks++; if (mem_addr !== 8'h08) $display("FAIL prio_mem_addr got=%h exp=08", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 16'hBEEF) $display("FAIL prio_mem_wdata got=%h exp=BEEF", mem_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_wren !== 1'b0) $display("FAIL prio_wren_t2 got=%b exp=0", mem_wren); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL prio_early got=%b exp=0", resp_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL prio_store_ack got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (resp_is_instr !== 1'b0) $display("FAIL prio_store_is_instr got=%b exp=0", resp_is_instr); else n_pass++;
        n_checks++; if (resp_data !== 16'h1234) $display("FAIL prio_store_keeps_data got=%h exp=1234", resp_data); else n_pass++;
        $display("txn store addr=0010 data=BEEF (fetch pending)");
        req_store = 1'b0;
        req_addr  = 16'h000A;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL prio_idle_t4 got=%b exp=0", stall); else n_pass++;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) $display("FAIL prio_fetch_accept got=%b exp=1", stall); else n_pass++;
        n_checks++; if (mem_addr !== 8'h05) $display("FAIL prio_fetch_addr got=%h exp=05", mem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1 || resp_is_instr !== 1'b1)
            $display("FAIL prio_fetch_resp got=%b%b exp=11", resp_valid, resp_is_instr); else n_pass++;
        $display("txn fetch addr=000A data=%h", resp_data);
        req_fetch = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_after_store;
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (2) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL ld_resp_valid got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (resp_is_instr !== 1'b0) $display("FAIL ld_is_instr got=%b exp=0", resp_is_instr); else n_pass++;
        n_checks++; if (resp_data !== 16'hBEEF) $display("FAIL ld_data got=%h exp=BEEF", resp_data); else n_pass++;
        $display("txn load addr=0010 data=%h", resp_data);
        req_load = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
        n_checks++; if (mem_addr !== 8'h09 || mem_wren !== 1'b1)
            $display("FAIL st2_drive got=%h/%b exp=09/1", mem_addr, mem_wren); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL st2_ack got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (resp_data !== 16'hBEEF) $display("FAIL st2_keeps_data got=%h exp=BEEF", resp_data); else n_pass++;
        $display("txn store addr=0012 data=0000");
        req_store = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000);
        repeat (2) @(negedge clk);
        n_checks++; if (resp_data !== 16'h0000) $display("FAIL st2_readback got=%h exp=0000", resp_data); else n_pass++;
        $display("txn load addr=0012 data=%h", resp_data);
        req_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alias;
        issue(1'b0, 1'b1, 1'b0, 16'h020A, 16'h0000);
        n_checks++; if (mem_addr !== 8'h05) $display("FAIL alias_mem_addr got=%h exp=05", mem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (resp_data !== 16'h1234) $display("FAIL alias_data got=%h exp=1234", resp_data); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL alias_err got=%b exp=0", misalign_err); else n_pass++;
        $display("txn load addr=020A data=%h", resp_data);
        req_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misalign;
        issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
`ifdef MEM_RESP_MISALIGN_EN
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL mis_resp_valid got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (misalign_err !== 1'b1) $display("FAIL mis_err got=%b exp=1", misalign_err); else n_pass++;
        n_checks++; if (mem_wren !== 1'b0) $display("FAIL mis_wren got=%b exp=0", mem_wren); else n_pass++;
        n_checks++; if (resp_data !== 16'h1234) $display("FAIL mis_data_kept got=%h exp=1234", resp_data); else n_pass++;
        $display("txn misaligned load addr=0003");
        req_load = 1'b0;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0 || misalign_err !== 1'b0)
            $display("FAIL mis_after got=%b%b exp=00", stall, misalign_err); else n_pass++;
`else
        n_checks++; if (mem_addr !== 8'h01) $display("FAIL odd_mem_addr got=%h exp=01", mem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL odd_resp_valid got=%b exp=1", resp_valid); else n_pass++;
        n_checks++; if (resp_data !== 16'hA0A1) $display("FAIL odd_data got=%h exp=A0A1", resp_data); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL odd_err got=%b exp=0", misalign_err); else n_pass++;
        $display("txn load addr=0003 data=%h", resp_data);
        req_load = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_long_latency;
        @(negedge clk);
        req_load_b = 1'b1;
        req_addr_b = 16'h0020;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++; if (stall_b !== 1'b1) $display("FAIL lat4_stall_t%0d got=%b exp=1", k, stall_b); else n_pass++;
            n_checks++; if (resp_valid_b !== (k == 6))
                $display("FAIL lat4_valid_t%0d got=%b exp=%b", k, resp_valid_b, (k == 6)); else n_pass++;
        end
        n_checks++; if (resp_data_b !== 16'hC310) $display("FAIL lat4_data got=%h exp=C310", resp_data_b); else n_pass++;
        $display("txn lat4 load addr=0020 data=%h", resp_data_b);
        req_load_b = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_b !== 1'b0) $display("FAIL lat4_idle got=%b exp=0", stall_b); else n_pass++;
    endtask

    task automatic test_reset_mid_store;
        issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1111);
        n_checks++; if (mem_wren !== 1'b1) $display("FAIL rst_wren_before got=%b exp=1", mem_wren); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (mem_wren !== 1'b0) $display("FAIL rst_wren_async got=%b exp=0", mem_wren); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall); else n_pass++;
        n_checks++; if (resp_data !== 16'h0000) $display("FAIL rst_resp_data got=%h exp=0000", resp_data); else n_pass++;
        req_store = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (resp_valid !== 1'b0 || stall !== 1'b0)
                $display("FAIL rst_no_resp_c%0d got=%b%b exp=00", k, resp_valid, stall); else n_pass++;
        end
        $display("txn store aborted by reset");
    endtask

    initial begin
        reset       = 1'b1;
        req_fetch   = 1'b0; req_load   = 1'b0; req_store   = 1'b0;
        req_addr    = '0;   req_wdata  = '0;
        req_fetch_b = 1'b0; req_load_b = 1'b0; req_store_b = 1'b0;
        req_addr_b  = '0;   req_wdata_b = '0;
        test_reset;
        test_fetch;
        test_priority;
        test_load_after_store;
        test_alias;
        test_misalign;
        test_long_latency;
        test_reset_mid_store;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
